pc_flag_unit: RTL and testbench

- Program-counter and condition-flag stage directly downstream of the 8-bit ALU.
- Latches the ALU's equal/lessThan outputs into a flags register.
- Evaluates conditional branches against the flags and sequences the PC through run and done states.
- Drives the instruction-memory address and the processor's top-level done indication.

---
 rtl/pc_flag_pkg.sv | 7 +
 rtl/pc_flag_unit_if.sv | 30 +++
 rtl/pc_flag_unit_branch_cond_eval.sv | 12 +
 rtl/pc_flag_unit.sv | 83 ++++++++
 tb/tb_pc_flag_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pc_flag_pkg.sv
// pc_flag_pkg: shared types and defaults for the PC/flag stage
// Contents: state_t (IDLE/RUN/DONE), br_cond_t (BR_ALWAYS/BR_EQ/BR_LT/BR_LTE), PC_W_DEF
package pc_flag_pkg;
   localparam int PC_W_DEF = 10;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef enum logic [1:0] {BR_ALWAYS = 2'b00, BR_EQ = 2'b01, BR_LT = 2'b10, BR_LTE = 2'b11} br_cond_t;
endpackage

// File: rtl/pc_flag_unit_if.sv
// pc_flag_unit_if: control/status bundle between decoder/ALU and the PC/flag stage
// master drives start, stall, done_instr, flag_we, alu_equal, alu_less_than, branch_en, branch_cond, branch_target
// slave drives pc, flag_eq, flag_lt, taken, running, done, instr_count, taken_count
interface pc_flag_unit_if import pc_flag_pkg::*; #(parameter int PC_W = PC_W_DEF) ();
   logic            start;
   logic            stall;
   logic            done_instr;
   logic            flag_we;
   logic            alu_equal;
   logic            alu_less_than;
   logic            branch_en;
   br_cond_t        branch_cond;
   logic [PC_W-1:0] branch_target;
   logic [PC_W-1:0] pc;
   logic            flag_eq;
   logic            flag_lt;
   logic            taken;
   logic            running;
   logic            done;
   logic [15:0]     instr_count;
   logic [15:0]     taken_count;
   modport master (
      output start, stall, done_instr, flag_we, alu_equal, alu_less_than, branch_en, branch_cond, branch_target,
      input  pc, flag_eq, flag_lt, taken, running, done, instr_count, taken_count
   );
   modport slave (
      input  start, stall, done_instr, flag_we, alu_equal, alu_less_than, branch_en, branch_cond, branch_target,
      output pc, flag_eq, flag_lt, taken, running, done, instr_count, taken_count
   );
endinterface

// File: rtl/pc_flag_unit_branch_cond_eval.sv
// branch_cond_eval: maps a branch condition and the registered flags to a match bit
// Ports: i_cond (condition code), i_flag_eq, i_flag_lt (registered flags), o_match
module branch_cond_eval import pc_flag_pkg::*; (
   input  br_cond_t i_cond,
   input  logic     i_flag_eq,
   input  logic     i_flag_lt,
   output logic     o_match
);
   assign o_match = (i_cond == BR_ALWAYS) ? 1'b1 :
                    (i_cond == BR_EQ)     ? i_flag_eq :
                    (i_cond == BR_LT)     ? i_flag_lt : (i_flag_eq | i_flag_lt);
endmodule

// File: rtl/pc_flag_unit.sv
// pc_flag_unit: program counter, condition flags and run/done sequencing behind the ALU
// Ports: clk, rst_n (async active-low), bus (pc_flag_unit_if.slave)
// Optional: define PC_FLAG_PERF_CNT_EN to build saturating retired/taken counters; otherwise they read 0
module pc_flag_unit import pc_flag_pkg::*; #(
   parameter int              PC_W       = PC_W_DEF,
   parameter logic [PC_W-1:0] START_ADDR = '0
) (
   input logic           clk,
   input logic           rst_n,
   pc_flag_unit_if.slave bus
);
   state_t          r_state, w_state_nx;
   logic [PC_W-1:0] r_pc, w_pc_nx;
   logic            r_eq, r_lt, w_eq_nx, w_lt_nx;
   logic            w_adv, w_start, w_match, w_taken;
   assign w_adv   = (r_state == RUN) & ~bus.stall;
   // start is only honoured outside RUN
   assign w_start = bus.start & (r_state != RUN);
   branch_cond_eval u_eval (
      .i_cond    (bus.branch_cond),
      .i_flag_eq (r_eq),
      .i_flag_lt (r_lt),
      .o_match   (w_match)
   );
   // halt suppresses any redirect; branches see the flags as they were before this cycle
   assign w_taken = bus.branch_en & w_adv & w_match & ~bus.done_instr;
   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_eq_nx    = r_eq;
      w_lt_nx    = r_lt;
      if (w_start) begin
         w_state_nx = RUN;
         w_pc_nx    = START_ADDR;
         w_eq_nx    = 1'b0;
         w_lt_nx    = 1'b0;
      end else if (w_adv) begin
         w_eq_nx    = bus.flag_we ? bus.alu_equal : r_eq;
         w_lt_nx    = bus.flag_we ? bus.alu_less_than : r_lt;
         w_state_nx = bus.done_instr ? DONE : RUN;
         w_pc_nx    = bus.done_instr ? r_pc : w_taken ? bus.branch_target : r_pc + PC_W'(1);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pc    <= START_ADDR;
         r_eq    <= 1'b0;
         r_lt    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
         r_eq    <= w_eq_nx;
         r_lt    <= w_lt_nx;
      end
   end
   assign bus.pc      = r_pc;
   assign bus.flag_eq = r_eq;
   assign bus.flag_lt = r_lt;
   assign bus.taken   = w_taken;
   assign bus.running = (r_state == RUN);
   assign bus.done    = (r_state == DONE);
`ifdef PC_FLAG_PERF_CNT_EN
   logic [15:0] r_icnt, r_tcnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_icnt <= '0;
         r_tcnt <= '0;
      end else if (w_start) begin
         r_icnt <= '0;
         r_tcnt <= '0;
      end else begin
         if (w_adv && r_icnt != 16'hFFFF) r_icnt <= r_icnt + 16'd1;
         if (w_taken && r_tcnt != 16'hFFFF) r_tcnt <= r_tcnt + 16'd1;
      end
   end
   assign bus.instr_count = r_icnt;
   assign bus.taken_count = r_tcnt;
`else
   assign bus.instr_count = 16'd0;
   assign bus.taken_count = 16'd0;
`endif
endmodule

// File: tb/tb_pc_flag_unit.sv
// tb_pc_flag_unit: directed and random stimulus against a behavioural model of pc_flag_unit
module tb_pc_flag_unit;
   import pc_flag_pkg::*;
   localparam int PC_W = 10;
   localparam int PC_MOD = 1 << PC_W;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   pc_flag_unit_if #(.PC_W(PC_W)) bus ();
   pc_flag_unit #(.PC_W(PC_W), .START_ADDR('0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   int n_chk = 0;
   int n_fail = 0;
   // model state: running/done bits, pc as plain integer, flags and counts
   bit m_run = 0, m_done = 0, m_eq = 0, m_lt = 0;
   int m_pc = 0, m_ic = 0, m_tc = 0;
   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic bit exp_taken();
      bit m;
      case (int'(bus.branch_cond))
         0: m = 1;
         1: m = m_eq;
         2: m = m_lt;
         default: m = m_eq || m_lt;
      endcase
      return m_run && !bus.stall && bus.branch_en && !bus.done_instr && m;
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run = 0; m_done = 0; m_pc = 0; m_eq = 0; m_lt = 0; m_ic = 0; m_tc = 0;
      end else begin
         bit t;
         t = exp_taken();
         if (!m_run) begin
            if (bus.start) begin
               m_run = 1; m_done = 0; m_pc = 0; m_eq = 0; m_lt = 0; m_ic = 0; m_tc = 0;
            end
         end else if (!bus.stall) begin
            m_ic = (m_ic < 65535) ? m_ic + 1 : m_ic;
            if (t) m_tc = (m_tc < 65535) ? m_tc + 1 : m_tc;
            if (bus.flag_we) begin
               m_eq = bus.alu_equal;
               m_lt = bus.alu_less_than;
            end
            if (bus.done_instr) begin
               m_run = 0;
               m_done = 1;
            end else m_pc = t ? int'(bus.branch_target) : (m_pc + 1) % PC_MOD;
         end
      end
   end
   always @(negedge clk) begin
      check("pc", int'(bus.pc), m_pc);
      check("flag_eq", int'(bus.flag_eq), int'(m_eq));
      check("flag_lt", int'(bus.flag_lt), int'(m_lt));
      check("running", int'(bus.running), int'(m_run));
      check("done", int'(bus.done), int'(m_done));
      check("taken", int'(bus.taken), int'(exp_taken()));
`ifdef PC_FLAG_PERF_CNT_EN
      check("instr_count", int'(bus.instr_count), m_ic);
      check("taken_count", int'(bus.taken_count), m_tc);
`else
      check("instr_count", int'(bus.instr_count), 0);
      check("taken_count", int'(bus.taken_count), 0);
`endif
   end
   task automatic clr();
      bus.start = 0; bus.stall = 0; bus.done_instr = 0; bus.flag_we = 0;
      bus.alu_equal = 0; bus.alu_less_than = 0; bus.branch_en = 0;
      bus.branch_cond = BR_ALWAYS; bus.branch_target = '0;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic br(input br_cond_t c, input int tgt);
      bus.branch_en = 1; bus.branch_cond = c; bus.branch_target = PC_W'(tgt);
   endtask
   initial begin
      int ic0;
      clr();
      #3;
      check("reset_pc", int'(bus.pc), 0);
      check("reset_running", int'(bus.running), 0);
      check("reset_done", int'(bus.done), 0);
      tick();
      rst_n = 1;
      bus.start = 1;
      tick();
      clr();
      check("start_pc", int'(bus.pc), 0);
      check("start_running", int'(bus.running), 1);
      tick(); tick(); tick();
      check("seq_pc3", int'(bus.pc), 3);
      check("seq_flags", int'({bus.flag_eq, bus.flag_lt}), 0);
      bus.flag_we = 1; bus.alu_equal = 1;
      tick();
      clr();
      check("cmp_eq", int'(bus.flag_eq), 1);
      br(BR_EQ, 'h20);
      #1;
      check("beq_taken", int'(bus.taken), 1);
      tick();
      clr();
      check("beq_pc", int'(bus.pc), 'h20);
      bus.flag_we = 1;
      tick();
      bus.alu_equal = 1;
      br(BR_EQ, 'h50);
      #1;
      check("simul_taken", int'(bus.taken), 0);
      tick();
      clr();
      check("simul_pc", int'(bus.pc), 'h22);
      check("simul_eq", int'(bus.flag_eq), 1);
      br(BR_ALWAYS, 5);
      tick();
      check("to5_pc", int'(bus.pc), 5);
      ic0 = int'(bus.instr_count);
`ifdef PC_FLAG_PERF_CNT_EN
      check("icnt_lit", ic0, 8);
      check("tcnt_lit", int'(bus.taken_count), 2);
`endif
      bus.stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall_taken", int'(bus.taken), 0);
         tick();
         check("stall_pc", int'(bus.pc), 5);
         check("stall_icnt", int'(bus.instr_count), ic0);
      end
      clr();
      br(BR_ALWAYS, 'h12);
      tick();
      bus.done_instr = 1;
      br(BR_ALWAYS, 'h30);
      #1;
      check("halt_taken", int'(bus.taken), 0);
      tick();
      clr();
      check("halt_done", int'(bus.done), 1);
      check("halt_pc", int'(bus.pc), 'h12);
      tick();
      check("halt_hold", int'(bus.pc), 'h12);
      bus.start = 1;
      tick();
      clr();
      check("restart_pc", int'(bus.pc), 0);
      check("restart_flags", int'({bus.flag_eq, bus.flag_lt}), 0);
      check("restart_done", int'(bus.done), 0);
      br(BR_ALWAYS, PC_MOD - 1);
      tick();
      clr();
      check("wrap_top", int'(bus.pc), PC_MOD - 1);
      tick();
      check("wrap_zero", int'(bus.pc), 0);
      tick(); tick();
      #2;
      rst_n = 0;
      #1;
      check("async_pc", int'(bus.pc), 0);
      check("async_running", int'(bus.running), 0);
      check("async_done", int'(bus.done), 0);
      tick();
      rst_n = 1;
      for (int i = 0; i < 3000; i++) begin
         bus.start = ($urandom_range(0, 19) == 0);
         bus.stall = ($urandom_range(0, 4) == 0);
         bus.done_instr = ($urandom_range(0, 39) == 0);
         bus.flag_we = $urandom_range(0, 1);
         bus.alu_equal = $urandom_range(0, 1);
         bus.alu_less_than = $urandom_range(0, 1);
         bus.branch_en = ($urandom_range(0, 2) == 0);
         bus.branch_cond = br_cond_t'($urandom_range(0, 3));
         bus.branch_target = PC_W'($urandom_range(0, PC_MOD - 1));
         tick();
      end
      clr();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
